// File: rtl/pcm_tdm_encode_sched_if.sv
// Bundle between the TDM frame scheduler and its surroundings (sample sources,
// shared lin->log compressor, FSK modulator).
//   frame_start : 1-cycle strobe requesting a frame
//   ch_valid    : per-channel sample available
//   ch_sample   : channel k sample at [13k+12:13k], sign-magnitude
//   ch_ready    : 1-cycle fetch strobe per channel
//   enc_lin     : sample presented to the compressor
//   enc_log     : compressor output code
//   tx_bit      : serial data, tx_bit_en marks the first clock of each bit
//   tx_sync     : high throughout the sync byte
//   busy, ovf   : frame in progress / rejected frame_start
// master = the environment, slave = the scheduler.
interface pcm_tdm_encode_sched_if #(
  parameter int unsigned NCH = 4
);
  logic               frame_start;
  logic [NCH-1:0]     ch_valid;
  logic [13*NCH-1:0]  ch_sample;
  logic [NCH-1:0]     ch_ready;
  logic [12:0]        enc_lin;
  logic [7:0]         enc_log;
  logic               tx_bit;
  logic               tx_bit_en;
  logic               tx_sync;
  logic               busy;
  logic               ovf;

  modport master (
    output frame_start, ch_valid, ch_sample, enc_log,
    input  ch_ready, enc_lin, tx_bit, tx_bit_en, tx_sync, busy, ovf
  );

  modport slave (
    input  frame_start, ch_valid, ch_sample, enc_log,
    output ch_ready, enc_lin, tx_bit, tx_bit_en, tx_sync, busy, ovf
  );
endinterface

// File: rtl/pcm_tdm_encode_sched.sv
// Frame scheduler for the shared PCM lin->log compressor in the FSK transmit path.
// A frame is a sync byte followed by NCH slot bytes, sent MSB-first at one bit
// per BIT_DIV clocks. The sample for slot j is fetched at the start of byte j
// (one byte ahead), pushed to the compressor, and its code captured ENC_LAT
// clocks later so it is ready when slot j begins.
// Ports: clk, rst (synchronous, active-high), io (slave side of the bundle).
module pcm_tdm_encode_sched #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned BIT_DIV   = 8,
  parameter int unsigned ENC_LAT   = 1,
  parameter logic [7:0]  SYNC_WORD = 8'h9B,
  parameter logic [7:0]  IDLE_CODE = 8'hD5
) (
  input  logic                  clk,
  input  logic                  rst,
  pcm_tdm_encode_sched_if.slave io
);

  localparam int unsigned SMP_W  = 13;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned DIV_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned SLOT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned LAT_W  = (ENC_LAT > 0) ? $clog2(ENC_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SYNC, SLOT} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [2:0]          bit_q, bit_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [SMP_W-1:0]    enc_lin_q, enc_lin_d;
  logic                cap_pend_q, cap_pend_d;
  logic [LAT_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic [NCH-1:0]      ch_ready_q, ch_ready_d;
  logic                tx_bit_en_q, tx_bit_en_d;
  logic                tx_sync_q, tx_sync_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic last_div, last_bit, last_slot, terminal, start;

  assign last_div  = (div_q == DIV_W'(BIT_DIV - 1));
  assign last_bit  = (bit_q == 3'd7);
  assign last_slot = (slot_q == SLOT_W'(NCH - 1));
  // Last clock of the last bit of the final slot: the only point a new frame may chain on.
  assign terminal  = (state_q == SLOT) && last_slot && last_bit && last_div;

  // One-hot fetch strobe for byte index idx; nothing for the final slot's byte.
  function automatic logic [NCH-1:0] ready_for(input int unsigned idx);
    logic [NCH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (k == idx) r[k] = 1'b1;
    end
    return r;
  endfunction

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    slot_d      = slot_q;
    shift_d     = shift_q;
    code_d      = code_q;
    enc_lin_d   = enc_lin_q;
    cap_pend_d  = cap_pend_q;
    cap_cnt_d   = cap_cnt_q;
    ch_ready_d  = '0;
    tx_bit_en_d = 1'b0;
    ovf_d       = 1'b0;
    start       = 1'b0;

    // Compressor code capture, ENC_LAT clocks after enc_lin changed.
    if (cap_pend_q) begin
      if (cap_cnt_q == '0) begin
        code_d     = io.enc_log;
        cap_pend_d = 1'b0;
      end else begin
        cap_cnt_d = cap_cnt_q - LAT_W'(1);
      end
    end

    // Fetch: ch_valid is only looked at on the strobe clock.
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_ready_q[k]) begin
        if (io.ch_valid[k]) begin
          enc_lin_d  = io.ch_sample[SMP_W*k +: SMP_W];
          cap_pend_d = 1'b1;
          cap_cnt_d  = LAT_W'(ENC_LAT);
        end else begin
          code_d     = IDLE_CODE;
          cap_pend_d = 1'b0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        shift_d = '0;
        if (io.frame_start) start = 1'b1;
      end
      SYNC, SLOT: begin
        if (io.frame_start && !terminal) ovf_d = 1'b1;
        if (!last_div) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d       = '0;
          tx_bit_en_d = 1'b1;
          if (!last_bit) begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[CODE_W-2:0], 1'b0};
          end else begin
            bit_d = '0;
            if (state_q == SYNC) begin
              state_d    = SLOT;
              slot_d     = '0;
              shift_d    = code_q;
              ch_ready_d = ready_for(32'd1);
            end else if (!last_slot) begin
              slot_d     = slot_q + SLOT_W'(1);
              shift_d    = code_q;
              ch_ready_d = ready_for(32'(slot_q) + 32'd2);
            end else if (io.frame_start) begin
              start = 1'b1;
            end else begin
              state_d     = IDLE;
              shift_d     = '0;
              tx_bit_en_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = SYNC;
      div_d       = '0;
      bit_d       = '0;
      slot_d      = '0;
      shift_d     = SYNC_WORD;
      tx_bit_en_d = 1'b1;
      ch_ready_d  = ready_for(32'd0);
    end

    tx_sync_d = (state_d == SYNC);
    busy_d    = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      slot_q      <= '0;
      shift_q     <= '0;
      code_q      <= '0;
      enc_lin_q   <= '0;
      cap_pend_q  <= 1'b0;
      cap_cnt_q   <= '0;
      ch_ready_q  <= '0;
      tx_bit_en_q <= 1'b0;
      tx_sync_q   <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      slot_q      <= slot_d;
      shift_q     <= shift_d;
      code_q      <= code_d;
      enc_lin_q   <= enc_lin_d;
      cap_pend_q  <= cap_pend_d;
      cap_cnt_q   <= cap_cnt_d;
      ch_ready_q  <= ch_ready_d;
      tx_bit_en_q <= tx_bit_en_d;
      tx_sync_q   <= tx_sync_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign io.ch_ready  = ch_ready_q;
  assign io.enc_lin   = enc_lin_q;
  assign io.tx_bit    = shift_q[CODE_W-1];
  assign io.tx_bit_en = tx_bit_en_q;
  assign io.tx_sync   = tx_sync_q;
  assign io.busy      = busy_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_pcm_tdm_encode_sched.sv
// Bench for pcm_tdm_encode_sched: three instances (ENC_LAT 1, 0, 5) share the
// stimulus, each with its own delayed lin->log compressor, and every cycle is
// checked against a frame-position reference model. Table-driven frames and
// hand sequences cover overflow, chained frames and mid-frame reset.
module tb_pcm_tdm_encode_sched;
  localparam int NCH  = 4;
  localparam int BD   = 2;
  localparam int FB   = 8 * BD;
  localparam int FL   = (NCH + 1) * FB;
  localparam logic [7:0] IDLE = 8'hD5;

  logic clk = 1'b0;
  logic rst;
  logic frame_start;
  logic [NCH-1:0]    ch_valid;
  logic [13*NCH-1:0] ch_sample;

  always #5 clk = ~clk;

  pcm_tdm_encode_sched_if #(.NCH(NCH)) if1 ();
  pcm_tdm_encode_sched_if #(.NCH(NCH)) if0 ();
  pcm_tdm_encode_sched_if #(.NCH(NCH)) if5 ();

  pcm_tdm_encode_sched #(.NCH(NCH), .BIT_DIV(BD), .ENC_LAT(1)) dut1 (.clk(clk), .rst(rst), .io(if1.slave));
  pcm_tdm_encode_sched #(.NCH(NCH), .BIT_DIV(BD), .ENC_LAT(0)) dut0 (.clk(clk), .rst(rst), .io(if0.slave));
  pcm_tdm_encode_sched #(.NCH(NCH), .BIT_DIV(BD), .ENC_LAT(5)) dut5 (.clk(clk), .rst(rst), .io(if5.slave));

  assign if1.frame_start = frame_start;
  assign if0.frame_start = frame_start;
  assign if5.frame_start = frame_start;
  assign if1.ch_valid    = ch_valid;
  assign if0.ch_valid    = ch_valid;
  assign if5.ch_valid    = ch_valid;
  assign if1.ch_sample   = ch_sample;
  assign if0.ch_sample   = ch_sample;
  assign if5.ch_sample   = ch_sample;

  // Reference compressor: sign, 3-bit segment, 4-bit mantissa.
  function automatic logic [7:0] lin2log(input logic [12:0] s);
    int mag, seg, sh;
    mag = int'(s[11:0]);
    seg = 0;
    for (int m = 11; m >= 5; m--) begin
      if (seg == 0 && mag >= (1 << m)) seg = m - 4;
    end
    sh = (seg == 0) ? 1 : seg;
    return {s[12], 3'(seg), 4'((mag >> sh) & 15)};
  endfunction

  logic [12:0] pipe1;
  logic [12:0] pipe5 [0:4];
  always @(posedge clk) begin
    pipe1 <= if1.enc_lin;
    pipe5[0] <= if5.enc_lin;
    for (int i = 1; i < 5; i++) pipe5[i] <= pipe5[i-1];
  end
  assign if1.enc_log = lin2log(pipe1);
  assign if0.enc_log = lin2log(if0.enc_lin);
  assign if5.enc_log = lin2log(pipe5[4]);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: position within the frame, bytes decided at their fetch clock.
  int          m_pos = -1;
  logic        m_ovf = 1'b0;
  logic [12:0] m_lin = '0;
  logic [7:0]  m_bytes [0:NCH] = '{default: 8'h9B};

  always @(posedge clk) begin
    if (rst) begin
      m_pos <= -1;
      m_lin <= '0;
      m_ovf <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (m_pos == k * FB) begin
          if (ch_valid[k]) begin
            m_lin        <= ch_sample[13*k +: 13];
            m_bytes[k+1] <= lin2log(ch_sample[13*k +: 13]);
          end else begin
            m_bytes[k+1] <= IDLE;
          end
        end
      end
      m_ovf <= (m_pos >= 0) && (m_pos != FL - 1) && frame_start;
      if (m_pos < 0)            m_pos <= frame_start ? 0 : -1;
      else if (m_pos == FL - 1) m_pos <= frame_start ? 0 : -1;
      else                      m_pos <= m_pos + 1;
    end
  end

  function automatic logic [21:0] model_vec();
    logic b, sy, en, tb;
    logic [NCH-1:0] rd;
    logic [7:0] by;
    b = (m_pos >= 0); sy = 1'b0; en = 1'b0; tb = 1'b0; rd = '0; by = '0;
    if (b) begin
      sy = (m_pos < FB);
      en = ((m_pos % BD) == 0);
      by = m_bytes[m_pos / FB];
      tb = by[7 - (m_pos % FB) / BD];
      for (int k = 0; k < NCH; k++) if (m_pos == k * FB) rd[k] = 1'b1;
    end
    return {b, sy, en, tb, m_ovf, rd, m_lin};
  endfunction

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_lat1", 80'({if1.busy, if1.tx_sync, if1.tx_bit_en, if1.tx_bit, if1.ovf, if1.ch_ready, if1.enc_lin}), 80'(model_vec()));
      check("cycle_lat0", 80'({if0.busy, if0.tx_sync, if0.tx_bit_en, if0.tx_bit, if0.ovf, if0.ch_ready, if0.enc_lin}), 80'(model_vec()));
      check("cycle_lat5", 80'({if5.busy, if5.tx_sync, if5.tx_bit_en, if5.tx_bit, if5.ovf, if5.ch_ready, if5.enc_lin}), 80'(model_vec()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame now and watch dut1 until busy drops; inj = clock to re-strobe frame_start.
  task automatic run_frame(input int inj, output logic [79:0] sh, output int nbits,
                           output int nbusy, output int nsync, output int ovf_at,
                           output int novf, output int badper);
    int last_en;
    sh = '0; nbits = 0; nbusy = 0; nsync = 0; ovf_at = 0; novf = 0; badper = 0; last_en = 0;
    frame_start = 1'b1;
    tick();
    for (int c = 1; c <= 200; c++) begin
      frame_start = (c == inj);
      @(negedge clk);
      if (!if1.busy) break;
      nbusy++;
      if (if1.tx_sync) nsync++;
      if (if1.ovf) begin ovf_at = c; novf++; end
      if (if1.tx_bit_en) begin
        sh = {sh[78:0], if1.tx_bit};
        nbits++;
        if (last_en != 0 && c - last_en != BD) badper++;
        last_en = c;
      end
      tick();
    end
    frame_start = 1'b0;
  endtask

  typedef struct {
    logic [NCH-1:0]    valid;
    logic [13*NCH-1:0] samples;
    logic [31:0]       codes;
  } vec_t;

  vec_t vecs [5];
  logic [79:0] sh;
  int nbits, nbusy, nsync, ovf_at, novf, badper;
  logic [39:0] f1;

  initial begin
    vecs[0] = '{4'b1111, {13'h0040, 13'h0000, 13'h1020, 13'h0FFF}, 32'h7F90_0020};
    vecs[1] = '{4'b1101, {13'h0040, 13'h0000, 13'h1020, 13'h0FFF}, 32'h7FD5_0020};
    vecs[2] = '{4'b1111, {13'h0800, 13'h0010, 13'h001F, 13'h1FFF}, 32'hFF0F_0870};
    vecs[3] = '{4'b0110, {13'h0FFF, 13'h1001, 13'h0123, 13'h1100}, 32'hD542_80D5};
    vecs[4] = '{4'b0000, {13'h0FFF, 13'h1001, 13'h0123, 13'h1100}, 32'hD5D5_D5D5};
    f1 = {8'h9B, 32'h7F90_0020};

    rst = 1'b1; frame_start = 1'b0; ch_valid = '0; ch_sample = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_state", 80'({if1.busy, if1.tx_sync, if1.tx_bit_en, if1.tx_bit, if1.ovf, if1.ch_ready, if1.enc_lin}), 80'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      ch_valid  = vecs[i].valid;
      ch_sample = vecs[i].samples;
      run_frame(0, sh, nbits, nbusy, nsync, ovf_at, novf, badper);
      check($sformatf("frame%0d_bytes", i), sh, 80'({8'h9B, vecs[i].codes}));
      check($sformatf("frame%0d_bits", i), 80'(nbits), 80'(40));
      check($sformatf("frame%0d_busy_clks", i), 80'(nbusy), 80'(FL));
      check($sformatf("frame%0d_sync_clks", i), 80'(nsync), 80'(FB));
      repeat (3) tick();
    end

    // frame_start mid-frame is rejected with a one-cycle ovf.
    ch_valid = vecs[0].valid; ch_sample = vecs[0].samples;
    run_frame(30, sh, nbits, nbusy, nsync, ovf_at, novf, badper);
    check("ovf_bytes", sh, 80'(f1));
    check("ovf_clock", 80'(ovf_at), 80'(31));
    check("ovf_count", 80'(novf), 80'(1));
    check("ovf_busy_clks", 80'(nbusy), 80'(FL));
    repeat (3) tick();

    // frame_start on the terminal clock chains a second frame with no gap.
    run_frame(FL, sh, nbits, nbusy, nsync, ovf_at, novf, badper);
    check("chain_bytes", sh, {f1, f1});
    check("chain_busy_clks", 80'(nbusy), 80'(2 * FL));
    check("chain_sync_clks", 80'(nsync), 80'(2 * FB));
    check("chain_bit_period", 80'(badper), 80'(0));
    check("chain_ovf", 80'(novf), 80'(0));
    repeat (3) tick();

    // Reset for two clocks at clock 40 aborts the frame.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (39) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", 80'({if1.busy, if1.tx_sync, if1.tx_bit_en, if1.tx_bit, if1.ovf, if1.ch_ready, if1.enc_lin}), 80'd0);
    repeat (4) tick();
    check("abort_idle", 80'({if5.busy, if5.tx_bit, if0.busy, if0.tx_bit}), 80'd0);
    run_frame(0, sh, nbits, nbusy, nsync, ovf_at, novf, badper);
    check("after_abort_bytes", sh, 80'(f1));
    check("after_abort_busy_clks", 80'(nbusy), 80'(FL));
    repeat (3) tick();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      ch_valid    = NCH'($urandom);
      ch_sample   = {13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom)};
      frame_start = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; frame_start = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
